// File: rtl/grid_pkg.sv
// Shared grid geometry, 640x480@60 VGA timing constants and colour codes
// for the grid renderer and its timing generator.
package grid_pkg;

  localparam int GRID_NX   = 32;
  localparam int GRID_NY   = 24;
  localparam int GRID_CELL = 20;
  localparam int GRID_DIV  = 4;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;
  localparam logic [11:0] RGB_RED   = 12'hF00;

endpackage

// File: rtl/grid_vga_renderer_vga_timing.sv
// Pixel-enable divider, h/v raster counters, registered sync outputs and a
// one-clock frame tick on the final pixel of each frame.
module vga_timing
  import grid_pkg::*;
#(
  parameter int DIV = GRID_DIV
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_pix_en,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic       o_line_end,
  output logic       o_frame_end,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_frame_tick
);

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] r_div;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_frame_tick;

  logic w_pix_en;
  logic w_line_end;
  logic w_frame_end;
  logic w_hs_n;
  logic w_vs_n;

  assign w_pix_en    = (r_div == DIV_LAST);
  assign w_line_end  = w_pix_en && (r_h == 10'(H_TOTAL - 1));
  assign w_frame_end = w_line_end && (r_v == 10'(V_TOTAL - 1));
  assign w_hs_n = !((r_h >= 10'(H_VIS + H_FP)) && (r_h < 10'(H_VIS + H_FP + H_SYNC)));
  assign w_vs_n = !((r_v >= 10'(V_VIS + V_FP)) && (r_v < 10'(V_VIS + V_FP + V_SYNC)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div        <= '0;
      r_h          <= '0;
      r_v          <= '0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (w_pix_en) begin
        r_div   <= '0;
        // Syncs decode the pixel being left, so they line up with the registered colour.
        r_hsync <= w_hs_n;
        r_vsync <= w_vs_n;
        if (w_line_end) begin
          r_h <= '0;
          r_v <= w_frame_end ? 10'd0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_pix_en     = w_pix_en;
  assign o_h          = r_h;
  assign o_v          = r_v;
  assign o_line_end   = w_line_end;
  assign o_frame_end  = w_frame_end;
  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/grid_vga_renderer.sv
// Renders an NX x NY cell grid onto 640x480 VGA: lit cells white, a red
// border on the cursor cell, black elsewhere and during blanking.
module grid_vga_renderer
  import grid_pkg::*;
#(
  parameter int NX   = GRID_NX,
  parameter int NY   = GRID_NY,
  parameter int CELL = GRID_CELL,
  parameter int DIV  = GRID_DIV
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NX*NY-1:0]   pixel_values_1d,
  input  logic [4:0]         cursor_x,
  input  logic [4:0]         cursor_y,
  output logic               hsync,
  output logic               vsync,
  output logic [11:0]        rgb,
  output logic               frame_tick
);

  localparam int            SW       = $clog2(CELL);
  localparam int            XW       = $clog2(H_TOTAL / CELL + 1);
  localparam int            YW       = $clog2(V_TOTAL / CELL + 1);
  localparam int            IW       = $clog2(NX * NY);
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL - 1);

  logic          w_pix_en;
  logic [9:0]    w_h;
  logic [9:0]    w_v;
  logic          w_line_end;
  logic          w_frame_end;
  logic          w_visible;
  logic          w_on_cursor;
  logic          w_on_border;
  logic [IW-1:0] w_idx;
  logic [11:0]   w_rgb;

  logic [SW-1:0] r_sub_x;
  logic [SW-1:0] r_sub_y;
  logic [XW-1:0] r_cell_x;
  logic [YW-1:0] r_cell_y;
  logic [11:0]   r_rgb;

  vga_timing #(.DIV(DIV)) u_timing (
    .i_clk        (clock),
    .i_rst_n      (reset_n),
    .o_pix_en     (w_pix_en),
    .o_h          (w_h),
    .o_v          (w_v),
    .o_line_end   (w_line_end),
    .o_frame_end  (w_frame_end),
    .o_hsync      (hsync),
    .o_vsync      (vsync),
    .o_frame_tick (frame_tick)
  );

  // Cell/sub-cell counters track h/v directly so no divider is needed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sub_x  <= '0;
      r_cell_x <= '0;
      r_sub_y  <= '0;
      r_cell_y <= '0;
    end else if (w_pix_en) begin
      if (w_line_end) begin
        r_sub_x  <= '0;
        r_cell_x <= '0;
        if (w_frame_end) begin
          r_sub_y  <= '0;
          r_cell_y <= '0;
        end else if (r_sub_y == SUB_LAST) begin
          r_sub_y  <= '0;
          r_cell_y <= r_cell_y + 1'b1;
        end else begin
          r_sub_y  <= r_sub_y + 1'b1;
        end
      end else if (r_sub_x == SUB_LAST) begin
        r_sub_x  <= '0;
        r_cell_x <= r_cell_x + 1'b1;
      end else begin
        r_sub_x  <= r_sub_x + 1'b1;
      end
    end
  end

  assign w_visible   = (w_h < 10'(H_VIS)) && (w_v < 10'(V_VIS));
  assign w_on_cursor = (int'(r_cell_x) == int'(cursor_x)) && (int'(r_cell_y) == int'(cursor_y));
  assign w_on_border = (r_sub_x == '0) || (r_sub_x == SUB_LAST) ||
                       (r_sub_y == '0) || (r_sub_y == SUB_LAST);
  assign w_idx       = IW'(int'(r_cell_x) * NY + int'(r_cell_y));

  always_comb begin
    w_rgb = RGB_BLACK;
    if (w_visible) begin
      if (w_on_cursor && w_on_border) begin
        w_rgb = RGB_RED;
      end else if (pixel_values_1d[w_idx]) begin
        w_rgb = RGB_WHITE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb <= RGB_BLACK;
    end else if (w_pix_en) begin
      r_rgb <= w_rgb;
    end
  end

  assign rgb = r_rgb;

endmodule

// File: tb/tb_grid_vga_renderer.sv
// Self-checking bench for grid_vga_renderer: a clock-count raster model predicts
// every output; scenario tasks add fixed-value checks at notable pixels.
module tb_grid_vga_renderer;

  localparam int NX = 32, NY = 24, CELL = 20, DIV = 4;
  localparam int H_TOT = 800, V_TOT = 525;
  localparam int FRAME_CLKS = H_TOT * V_TOT * DIV;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [NX*NY-1:0] pixel_values_1d = '0;
  logic [4:0]       cursor_x = 5'd0;
  logic [4:0]       cursor_y = 5'd31;
  logic             hsync, vsync, frame_tick;
  logic [11:0]      rgb;

  int checks = 0;
  int fails  = 0;

  // Reference model state: pixel currently on the outputs and its expected outputs.
  int unsigned clk_cnt = 0;
  int          cur_h = 0, cur_v = 0;
  logic        exp_hs = 1'b1, exp_vs = 1'b1, exp_ft = 1'b0;
  logic [11:0] exp_rgb = 12'h000;

  grid_vga_renderer #(.NX(NX), .NY(NY), .CELL(CELL), .DIV(DIV)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pixel_values_1d (pixel_values_1d),
    .cursor_x        (cursor_x),
    .cursor_y        (cursor_y),
    .hsync           (hsync),
    .vsync           (vsync),
    .rgb             (rgb),
    .frame_tick      (frame_tick)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] model_rgb(int h, int v);
    int cx, cy, sx, sy;
    if (h >= 640 || v >= 480) return 12'h000;
    cx = h / CELL; cy = v / CELL; sx = h % CELL; sy = v % CELL;
    if (cx == int'(cursor_x) && cy == int'(cursor_y) &&
        (sx == 0 || sx == CELL - 1 || sy == 0 || sy == CELL - 1)) return 12'hF00;
    if (pixel_values_1d[cx * NY + cy]) return 12'hFFF;
    return 12'h000;
  endfunction

  // Pixel n (0-based since reset) reaches the outputs at clock edge DIV*(n+1).
  always @(posedge clock or negedge reset_n) begin : model
    int unsigned k;
    int h, v;
    if (!reset_n) begin
      clk_cnt <= 0; cur_h <= 0; cur_v <= 0;
      exp_hs <= 1'b1; exp_vs <= 1'b1; exp_rgb <= 12'h000; exp_ft <= 1'b0;
    end else begin
      k = clk_cnt + 1;
      clk_cnt <= k;
      exp_ft <= 1'b0;
      if (k % DIV == 0) begin
        h = int'((k / DIV - 1) % H_TOT);
        v = int'(((k / DIV - 1) / H_TOT) % V_TOT);
        cur_h   <= h;
        cur_v   <= v;
        exp_hs  <= !(h >= 656 && h < 752);
        exp_vs  <= !(v >= 490 && v < 492);
        exp_rgb <= model_rgb(h, v);
        exp_ft  <= (h == H_TOT - 1 && v == V_TOT - 1);
      end
    end
  end

  task automatic randomize_inputs();
    for (int k = 0; k < NX * NY / 32; k++) pixel_values_1d[k*32 +: 32] = $urandom();
    cursor_x = 5'($urandom_range(0, 31));
    cursor_y = 5'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (hsync !== 1'b1) begin fails++; $display("FAIL reset_hsync got=%b want=1", hsync); end
    checks++; if (vsync !== 1'b1) begin fails++; $display("FAIL reset_vsync got=%b want=1", vsync); end
    checks++; if (rgb !== 12'h000) begin fails++; $display("FAIL reset_rgb got=%h want=000", rgb); end
    checks++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    randomize_inputs();
    reset_n = 1'b1;
  endtask

  // Full frame from reset release: model compare every clock plus sync/tick counts.
  task automatic test_frame_timing();
    int shown = 0, hs_run = 0, vs_run = 0, hs_pulses = 0, vs_pulses = 0, ticks = 0, tick_at = -1;
    for (int i = 1; i <= FRAME_CLKS; i++) begin
      @(negedge clock);
      checks++;
      if ({hsync, vsync, frame_tick, rgb} !== {exp_hs, exp_vs, exp_ft, exp_rgb}) begin
        fails++;
        if (shown++ < 10) $display("FAIL frame_model clk=%0d h=%0d v=%0d got %b%b%b %h want %b%b%b %h",
          i, cur_h, cur_v, hsync, vsync, frame_tick, rgb, exp_hs, exp_vs, exp_ft, exp_rgb);
      end
      if (!hsync) hs_run++;
      else if (hs_run != 0) begin
        hs_pulses++;
        checks++;
        if (hs_run != 96 * DIV) begin
          fails++;
          if (shown++ < 10) $display("FAIL hsync_width got=%0d want=%0d", hs_run, 96 * DIV);
        end
        hs_run = 0;
      end
      if (!vsync) vs_run++;
      else if (vs_run != 0) begin
        vs_pulses++;
        checks++;
        if (vs_run != 2 * H_TOT * DIV) begin
          fails++; $display("FAIL vsync_width got=%0d want=%0d", vs_run, 2 * H_TOT * DIV);
        end
        vs_run = 0;
      end
      if (frame_tick) begin ticks++; tick_at = i; end
      if (i % 100000 == 0) randomize_inputs();
    end
    checks++; if (hs_pulses != V_TOT) begin fails++; $display("FAIL hsync_count got=%0d want=%0d", hs_pulses, V_TOT); end
    checks++; if (vs_pulses != 1) begin fails++; $display("FAIL vsync_count got=%0d want=1", vs_pulses); end
    checks++; if (ticks != 1) begin fails++; $display("FAIL tick_count got=%0d want=1", ticks); end
    checks++; if (tick_at != FRAME_CLKS) begin fails++; $display("FAIL tick_time got=%0d want=%0d", tick_at, FRAME_CLKS); end
  endtask

  // One frame in three phases: corner cell, cursor on a full grid, opposite corner cell.
  task automatic test_cell_patterns();
    int shown = 0, phase = 0;
    bit started = 0, done = 0, chk;
    logic [11:0] want;
    pixel_values_1d = '0; pixel_values_1d[0] = 1'b1;
    cursor_x = 5'($urandom_range(0, 31)); cursor_y = 5'd31;
    for (int i = 0; i < FRAME_CLKS + 64 && !done; i++) begin
      @(negedge clock);
      if (cur_v == 0) started = 1;
      checks++;
      if ({hsync, vsync, frame_tick, rgb} !== {exp_hs, exp_vs, exp_ft, exp_rgb}) begin
        fails++;
        if (shown++ < 10) $display("FAIL pattern_model h=%0d v=%0d got %b%b%b %h want %b%b%b %h",
          cur_h, cur_v, hsync, vsync, frame_tick, rgb, exp_hs, exp_vs, exp_ft, exp_rgb);
      end
      chk = 0; want = 12'h000;
      if (started && phase == 0 && cur_v < 30) begin
        chk = 1; want = (cur_h < 20 && cur_v < 20) ? 12'hFFF : 12'h000;
      end else if (phase == 1 && cur_v >= 60 && cur_v <= 79) begin
        if (cur_h == 100 || cur_h == 119) begin chk = 1; want = 12'hF00; end
        else if (cur_v == 70 && (cur_h == 110 || cur_h == 99)) begin chk = 1; want = 12'hFFF; end
        else if (cur_h >= 640) begin chk = 1; want = 12'h000; end
      end else if (phase == 2 && cur_v >= 300 && cur_v < 480 && cur_h < 640) begin
        chk = 1; want = (cur_h >= 620 && cur_v >= 460) ? 12'hFFF : 12'h000;
      end
      if (chk) begin
        checks++;
        if (rgb !== want) begin
          fails++;
          if (shown++ < 10) $display("FAIL pattern_rgb phase=%0d h=%0d v=%0d got=%h want=%h", phase, cur_h, cur_v, rgb, want);
        end
      end
      if (started && phase == 0 && cur_v == 40) begin
        phase = 1; pixel_values_1d = '1; cursor_x = 5'd5; cursor_y = 5'd3;
      end else if (phase == 1 && cur_v == 200) begin
        phase = 2; pixel_values_1d = '0; pixel_values_1d[31*24+23] = 1'b1; cursor_y = 5'd31;
      end
      if (started && cur_h == H_TOT - 1 && cur_v == V_TOT - 1) done = 1;
    end
    checks++; if (!done) begin fails++; $display("FAIL pattern_timeout got=not_done want=frame_end"); end
  endtask

  // Empty grid with cursor row off the grid: every pixel black.
  task automatic test_all_zero();
    int shown = 0;
    bit started = 0, done = 0;
    pixel_values_1d = '0;
    cursor_y = 5'($urandom_range(NY, 31));
    for (int i = 0; i < FRAME_CLKS + 64 && !done; i++) begin
      @(negedge clock);
      if (cur_v == 0) started = 1;
      checks++;
      if (rgb !== 12'h000) begin
        fails++;
        if (shown++ < 10) $display("FAIL zero_rgb h=%0d v=%0d got=%h want=000", cur_h, cur_v, rgb);
      end
      checks++;
      if ({hsync, vsync, frame_tick} !== {exp_hs, exp_vs, exp_ft}) begin
        fails++;
        if (shown++ < 10) $display("FAIL zero_sync h=%0d v=%0d got %b%b%b want %b%b%b",
          cur_h, cur_v, hsync, vsync, frame_tick, exp_hs, exp_vs, exp_ft);
      end
      if (i % 50000 == 0) begin
        cursor_x = 5'($urandom_range(0, 31));
        cursor_y = 5'($urandom_range(NY, 31));
      end
      if (started && cur_h == H_TOT - 1 && cur_v == V_TOT - 1) done = 1;
    end
    checks++; if (!done) begin fails++; $display("FAIL zero_timeout got=not_done want=frame_end"); end
  endtask

  // Reset inside the hsync pulse on line 200, then time the next frame tick.
  task automatic test_mid_frame_reset();
    int shown = 0, tick_at = -1;
    bit found = 0;
    randomize_inputs();
    for (int i = 0; i < FRAME_CLKS && !found; i++) begin
      @(negedge clock);
      checks++;
      if ({hsync, vsync, frame_tick, rgb} !== {exp_hs, exp_vs, exp_ft, exp_rgb}) begin
        fails++;
        if (shown++ < 10) $display("FAIL prereset_model h=%0d v=%0d got %b%b%b %h want %b%b%b %h",
          cur_h, cur_v, hsync, vsync, frame_tick, rgb, exp_hs, exp_vs, exp_ft, exp_rgb);
      end
      if (cur_h == 700 && cur_v == 200) found = 1;
    end
    checks++; if (!found) begin fails++; $display("FAIL midreset_reach got=not_found want=h700_v200"); end
    reset_n = 1'b0;
    #1;
    checks++; if (hsync !== 1'b1) begin fails++; $display("FAIL midreset_hsync got=%b want=1", hsync); end
    checks++; if (vsync !== 1'b1) begin fails++; $display("FAIL midreset_vsync got=%b want=1", vsync); end
    checks++; if (rgb !== 12'h000) begin fails++; $display("FAIL midreset_rgb got=%h want=000", rgb); end
    checks++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL midreset_tick got=%b want=0", frame_tick); end
    repeat (3) begin
      @(negedge clock);
      checks++;
      if ({hsync, vsync, rgb} !== {1'b1, 1'b1, 12'h000}) begin
        fails++; $display("FAIL midreset_hold got %b%b %h want 11 000", hsync, vsync, rgb);
      end
    end
    reset_n = 1'b1;
    for (int i = 1; i <= FRAME_CLKS + 16 && tick_at < 0; i++) begin
      @(negedge clock);
      checks++;
      if ({hsync, vsync, frame_tick, rgb} !== {exp_hs, exp_vs, exp_ft, exp_rgb}) begin
        fails++;
        if (shown++ < 10) $display("FAIL postreset_model h=%0d v=%0d got %b%b%b %h want %b%b%b %h",
          cur_h, cur_v, hsync, vsync, frame_tick, rgb, exp_hs, exp_vs, exp_ft, exp_rgb);
      end
      if (frame_tick) tick_at = i;
      if (i % 200000 == 0) randomize_inputs();
    end
    checks++;
    if (tick_at != FRAME_CLKS) begin fails++; $display("FAIL postreset_tick_time got=%0d want=%0d", tick_at, FRAME_CLKS); end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_cell_patterns();
    test_all_zero();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
